// File: rtl/wired_dsram_wr_arb_pkg.sv
// Shared dcache write-port types: tag layout, SRAM write bundle and snoop
// record, plus the way-select decode used by every tag write.
package wired_dsram_wr_arb_pkg;

  localparam int CACHE_TAG_W = 22;
  localparam int IDX_W       = 8;
  localparam int WAY_W       = 2;
  localparam int NUM_WAYS    = 4;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 128;
  localparam int STRB_W      = 16;

  typedef struct packed {
    logic [19:0] ppn;
    logic        rp;
    logic        wp;
  } cache_tag_t;

  // One write to the data/tag arrays. The same record is registered as the
  // snoop, so fields a requester does not write stay zero.
  typedef struct packed {
    logic [IDX_W-1:0]    addr;
    logic [WAY_W-1:0]    way;
    logic [LINE_W-1:0]   wdata;
    logic [STRB_W-1:0]   strb;
    logic [NUM_WAYS-1:0] twe;
    cache_tag_t          tag;
  } dsram_wr_t;

  typedef struct packed {
    logic      valid;
    dsram_wr_t wr;
  } dsram_snoop_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RF,
    GNT_COP,
    GNT_SB
  } gnt_src_e;

  localparam logic [NUM_WAYS-1:0][NUM_WAYS-1:0] WAY_ONEHOT =
    {4'b1000, 4'b0100, 4'b0010, 4'b0001};

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
    return WAY_ONEHOT[way];
  endfunction

endpackage

// File: rtl/wired_dsram_wr_arb_if.sv
// Requester handshakes, SRAM write controls and snoop broadcast of the
// dcache write-port arbiter. The arbiter uses the slave view; requesters
// and the SRAM/LSU side use the master view.
interface wired_dsram_wr_arb_if
  import wired_dsram_wr_arb_pkg::*;
#(
  parameter int TAG_W = CACHE_TAG_W
) ();

  logic                rf_valid_i;
  logic                rf_ready_o;
  logic [IDX_W-1:0]    rf_addr_i;
  logic [WAY_W-1:0]    rf_way_i;
  logic [LINE_W-1:0]   rf_data_i;
  logic [TAG_W-1:0]    rf_tag_i;

  logic                cop_valid_i;
  logic                cop_ready_o;
  logic [IDX_W-1:0]    cop_addr_i;
  logic [WAY_W-1:0]    cop_way_i;

  logic                sb_valid_i;
  logic                sb_ready_o;
  logic [9:0]          sb_addr_i;
  logic [WAY_W-1:0]    sb_way_i;
  logic [WORD_W-1:0]   sb_data_i;
  logic [3:0]          sb_strb_i;

  logic                d_we_o;
  logic [IDX_W-1:0]    d_addr_o;
  logic [WAY_W-1:0]    d_way_o;
  logic [LINE_W-1:0]   d_wdata_o;
  logic [STRB_W-1:0]   d_strb_o;
  logic [NUM_WAYS-1:0] t_we_o;
  logic [IDX_W-1:0]    t_addr_o;
  logic [TAG_W-1:0]    t_wtag_o;

  logic                snp_valid_o;
  logic [IDX_W-1:0]    snp_daddr_o;
  logic [WAY_W-1:0]    snp_dway_o;
  logic [LINE_W-1:0]   snp_d_o;
  logic [STRB_W-1:0]   snp_dstrb_o;
  logic [IDX_W-1:0]    snp_taddr_o;
  logic [NUM_WAYS-1:0] snp_twe_o;
  logic [TAG_W-1:0]    snp_tag_o;

  modport slave (
    input  rf_valid_i, rf_addr_i, rf_way_i, rf_data_i, rf_tag_i,
    input  cop_valid_i, cop_addr_i, cop_way_i,
    input  sb_valid_i, sb_addr_i, sb_way_i, sb_data_i, sb_strb_i,
    output rf_ready_o, cop_ready_o, sb_ready_o,
    output d_we_o, d_addr_o, d_way_o, d_wdata_o, d_strb_o,
    output t_we_o, t_addr_o, t_wtag_o,
    output snp_valid_o, snp_daddr_o, snp_dway_o, snp_d_o, snp_dstrb_o,
    output snp_taddr_o, snp_twe_o, snp_tag_o
  );

  modport master (
    output rf_valid_i, rf_addr_i, rf_way_i, rf_data_i, rf_tag_i,
    output cop_valid_i, cop_addr_i, cop_way_i,
    output sb_valid_i, sb_addr_i, sb_way_i, sb_data_i, sb_strb_i,
    input  rf_ready_o, cop_ready_o, sb_ready_o,
    input  d_we_o, d_addr_o, d_way_o, d_wdata_o, d_strb_o,
    input  t_we_o, t_addr_o, t_wtag_o,
    input  snp_valid_o, snp_daddr_o, snp_dway_o, snp_d_o, snp_dstrb_o,
    input  snp_taddr_o, snp_twe_o, snp_tag_o
  );

endinterface

// File: rtl/wired_starve_cnt.sv
// Saturating lost-arbitration counter with a registered priority flag.
// The flag rises the cycle after the count reaches LIMIT and drops the
// cycle after the requester finally wins.
module wired_starve_cnt #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lost,
  input  logic won,
  output logic prio_q
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear on a win, otherwise count losses up to the limit
  always_comb begin
    cnt_next = cnt_q;
    if (won) begin
      cnt_next = '0;
    end else if (lost && (cnt_q < LIMIT_C)) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // Count and priority flag, both derived from the same next-count value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prio_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      prio_q <= (cnt_next >= LIMIT_C);
    end
  end

endmodule

// File: rtl/wired_dsram_wr_arb.sv
// Single write port arbiter for the dcache data and tag SRAMs. Picks one of
// refill, cacop invalidate or store-buffer drain each cycle, drives the SRAM
// write controls combinationally and registers the write as a one-cycle
// snoop so LSU M1/skid stages can patch data read in the same cycle.
module wired_dsram_wr_arb
  import wired_dsram_wr_arb_pkg::*;
#(
  parameter int TAG_W        = CACHE_TAG_W,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wired_dsram_wr_arb_if.slave   bus
);

  gnt_src_e     gnt;
  logic         sb_prio_q;
  logic         d_we;
  dsram_wr_t    wr;
  dsram_snoop_t snp_q;

  // Grant selection; nothing is granted while reset is asserted so a
  // requester never sees a completed transfer that the SRAM did not take
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (sb_prio_q && bus.sb_valid_i) begin
        gnt = GNT_SB;
      end else if (bus.rf_valid_i) begin
        gnt = GNT_RF;
      end else if (bus.cop_valid_i) begin
        gnt = GNT_COP;
      end else if (bus.sb_valid_i) begin
        gnt = GNT_SB;
      end
    end
  end

  assign bus.rf_ready_o  = (gnt == GNT_RF);
  assign bus.cop_ready_o = (gnt == GNT_COP);
  assign bus.sb_ready_o  = (gnt == GNT_SB);

  // Store buffer starvation tracking
  wired_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .lost   (bus.sb_valid_i && !bus.sb_ready_o),
    .won    (bus.sb_ready_o),
    .prio_q (sb_prio_q)
  );

  // Build the write bundle for the granted requester; unwritten fields stay 0
  always_comb begin
    wr   = '0;
    d_we = 1'b0;
    case (gnt)
      GNT_RF: begin
        d_we     = 1'b1;
        wr.addr  = bus.rf_addr_i;
        wr.way   = bus.rf_way_i;
        wr.wdata = bus.rf_data_i;
        wr.strb  = '1;
        wr.twe   = way_onehot(bus.rf_way_i);
        wr.tag   = cache_tag_t'(bus.rf_tag_i[TAG_W-1:0]);
      end
      GNT_COP: begin
        wr.addr = bus.cop_addr_i;
        wr.way  = bus.cop_way_i;
        wr.twe  = way_onehot(bus.cop_way_i);
      end
      GNT_SB: begin
        d_we     = 1'b1;
        wr.addr  = bus.sb_addr_i[9:2];
        wr.way   = bus.sb_way_i;
        wr.wdata = {4{bus.sb_data_i}};
        wr.strb  = STRB_W'(bus.sb_strb_i) << {bus.sb_addr_i[1:0], 2'b00};
      end
      default: begin
      end
    endcase
  end

  assign bus.d_we_o    = d_we;
  assign bus.d_addr_o  = wr.addr;
  assign bus.d_way_o   = wr.way;
  assign bus.d_wdata_o = wr.wdata;
  assign bus.d_strb_o  = wr.strb;
  assign bus.t_we_o    = wr.twe;
  assign bus.t_addr_o  = wr.addr;
  assign bus.t_wtag_o  = wr.tag;

  // Snoop register: copy of this cycle's write, visible for one cycle only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snp_q <= '0;
    end else begin
      snp_q.valid <= (gnt != GNT_NONE);
      snp_q.wr    <= wr;
    end
  end

  assign bus.snp_valid_o = snp_q.valid;
  assign bus.snp_daddr_o = snp_q.wr.addr;
  assign bus.snp_dway_o  = snp_q.wr.way;
  assign bus.snp_d_o     = snp_q.wr.wdata;
  assign bus.snp_dstrb_o = snp_q.wr.strb;
  assign bus.snp_taddr_o = snp_q.wr.addr;
  assign bus.snp_twe_o   = snp_q.wr.twe;
  assign bus.snp_tag_o   = snp_q.wr.tag;

endmodule

// File: tb/tb_wired_dsram_wr_arb.sv
// Scoreboard bench for the dcache write-port arbiter. Stimulus pushes the
// hand-computed write and its snoop (one cycle later) into queues; a monitor
// pops and compares whenever the DUT shows a grant/write or a snoop.
module tb_wired_dsram_wr_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    int           cyc;
    logic [2:0]   rdy;
    logic         dwe;
    logic [7:0]   addr;
    logic [1:0]   way;
    logic [127:0] wdata;
    logic [15:0]  strb;
    logic [3:0]   twe;
    logic [21:0]  tag;
  } exp_t;

  exp_t wq[$];
  exp_t sq[$];
  exp_t got_w;
  exp_t got_s;

  localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_B = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] LINE_C = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  wired_dsram_wr_arb_if #(.TAG_W(22)) bus ();

  wired_dsram_wr_arb #(
    .TAG_W        (22),
    .STARVE_LIMIT (8),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and cycle index
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [2:0] rdy, input logic dwe,
                              input logic [7:0] addr, input logic [1:0] way,
                              input logic [127:0] wdata, input logic [15:0] strb,
                              input logic [3:0] twe, input logic [21:0] tag);
    exp_t e;
    e.cyc = c; e.rdy = rdy; e.dwe = dwe; e.addr = addr; e.way = way;
    e.wdata = wdata; e.strb = strb; e.twe = twe; e.tag = tag;
    return e;
  endfunction

  task automatic applyStimulus(input exp_t e);
    wq.push_back(e);
    e.cyc = e.cyc + 1;
    sq.push_back(e);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rf_valid_i  = 1'b0;
    bus.cop_valid_i = 1'b0;
    bus.sb_valid_i  = 1'b0;
  endtask

  // Monitor: compare every presented write and snoop against the queues
  always @(negedge clk) begin
    if (bus.rf_ready_o || bus.cop_ready_o || bus.sb_ready_o || bus.d_we_o || (|bus.t_we_o)) begin
      if (wq.size() == 0) begin
        checkOutput("wr_unexpected", {bus.rf_ready_o, bus.cop_ready_o, bus.sb_ready_o, bus.d_we_o, bus.t_we_o}, 128'h0);
      end else begin
        got_w = wq.pop_front();
        checkOutput("wr_cycle", 128'(cyc), 128'(got_w.cyc));
        checkOutput("wr_ready", {bus.rf_ready_o, bus.cop_ready_o, bus.sb_ready_o}, got_w.rdy);
        checkOutput("wr_d_we", bus.d_we_o, got_w.dwe);
        checkOutput("wr_d_addr", bus.d_addr_o, got_w.addr);
        checkOutput("wr_t_addr", bus.t_addr_o, got_w.addr);
        checkOutput("wr_d_way", bus.d_way_o, got_w.way);
        checkOutput("wr_d_wdata", bus.d_wdata_o, got_w.wdata);
        checkOutput("wr_d_strb", bus.d_strb_o, got_w.strb);
        checkOutput("wr_t_we", bus.t_we_o, got_w.twe);
        checkOutput("wr_t_wtag", bus.t_wtag_o, got_w.tag);
      end
    end
    if (bus.snp_valid_o) begin
      if (sq.size() == 0) begin
        checkOutput("snp_unexpected", bus.snp_valid_o, 128'h0);
      end else begin
        got_s = sq.pop_front();
        checkOutput("snp_cycle", 128'(cyc), 128'(got_s.cyc));
        checkOutput("snp_daddr", bus.snp_daddr_o, got_s.addr);
        checkOutput("snp_taddr", bus.snp_taddr_o, got_s.addr);
        checkOutput("snp_dway", bus.snp_dway_o, got_s.way);
        checkOutput("snp_d", bus.snp_d_o, got_s.wdata);
        checkOutput("snp_dstrb", bus.snp_dstrb_o, got_s.strb);
        checkOutput("snp_twe", bus.snp_twe_o, got_s.twe);
        checkOutput("snp_tag", bus.snp_tag_o, got_s.tag);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    int rf_n;
    logic [31:0] rf_word;

    bus.rf_valid_i = 1'b0; bus.rf_addr_i = '0; bus.rf_way_i = '0; bus.rf_data_i = '0; bus.rf_tag_i = '0;
    bus.cop_valid_i = 1'b0; bus.cop_addr_i = '0; bus.cop_way_i = '0;
    bus.sb_valid_i = 1'b0; bus.sb_addr_i = '0; bus.sb_way_i = '0; bus.sb_data_i = '0; bus.sb_strb_i = '0;

    // Reset: a refill request during reset must not be granted
    stepCycle();
    bus.rf_valid_i = 1'b1; bus.rf_addr_i = 8'h55; bus.rf_data_i = LINE_A; bus.rf_tag_i = 22'h3;
    @(negedge clk);
    checkOutput("rst_rf_ready", bus.rf_ready_o, 1'b0);
    checkOutput("rst_d_we", bus.d_we_o, 1'b0);
    checkOutput("rst_t_we", bus.t_we_o, 4'h0);
    checkOutput("rst_d_wdata", bus.d_wdata_o, 128'h0);
    checkOutput("rst_snp_valid", bus.snp_valid_o, 1'b0);
    checkOutput("rst_snp_d", bus.snp_d_o, 128'h0);
    checkOutput("rst_cnt", dut.u_starve.cnt_q, 4'd0);
    checkOutput("rst_prio", dut.sb_prio_q, 1'b0);
    stepCycle();
    rst_n = 1'b1;
    idle();

    // Refill alone: way 2 -> tag enable 0100, full strobe
    stepCycle();
    bus.rf_valid_i = 1'b1; bus.rf_addr_i = 8'h3C; bus.rf_way_i = 2'd2;
    bus.rf_data_i = LINE_A; bus.rf_tag_i = 22'h2A5A5A;
    applyStimulus(mk(cyc, 3'b100, 1'b1, 8'h3C, 2'd2, LINE_A, 16'hFFFF, 4'b0100, 22'h2A5A5A));
    stepCycle();
    idle();
    @(negedge clk);
    checkOutput("rf_snp_valid", bus.snp_valid_o, 1'b1);
    stepCycle();
    @(negedge clk);
    checkOutput("rf_snp_drop", bus.snp_valid_o, 1'b0);

    // Store word: addr 0F2 -> line 3C, word 2 -> strobe nibble [11:8]
    stepCycle();
    bus.sb_valid_i = 1'b1; bus.sb_addr_i = 10'h0F2; bus.sb_way_i = 2'd1;
    bus.sb_data_i = 32'hDEADBEEF; bus.sb_strb_i = 4'b0011;
    applyStimulus(mk(cyc, 3'b001, 1'b1, 8'h3C, 2'd1, {4{32'hDEADBEEF}}, 16'h0300, 4'b0000, 22'h0));

    // Cacop straight after: back-to-back snoops, tag-only write
    stepCycle();
    idle();
    bus.cop_valid_i = 1'b1; bus.cop_addr_i = 8'h01; bus.cop_way_i = 2'd3;
    applyStimulus(mk(cyc, 3'b010, 1'b0, 8'h01, 2'd3, 128'h0, 16'h0, 4'b1000, 22'h0));

    // Contention: refill, then cacop, then store word 123 (line 48, word 3)
    stepCycle();
    idle();
    bus.rf_valid_i = 1'b1; bus.rf_addr_i = 8'h10; bus.rf_way_i = 2'd0;
    bus.rf_data_i = LINE_B; bus.rf_tag_i = 22'h1F00F;
    bus.cop_valid_i = 1'b1; bus.cop_addr_i = 8'h20; bus.cop_way_i = 2'd1;
    bus.sb_valid_i = 1'b1; bus.sb_addr_i = 10'h123; bus.sb_way_i = 2'd2;
    bus.sb_data_i = 32'hCAFEF00D; bus.sb_strb_i = 4'b1111;
    applyStimulus(mk(cyc, 3'b100, 1'b1, 8'h10, 2'd0, LINE_B, 16'hFFFF, 4'b0001, 22'h1F00F));
    stepCycle();
    bus.rf_valid_i = 1'b0;
    applyStimulus(mk(cyc, 3'b010, 1'b0, 8'h20, 2'd1, 128'h0, 16'h0, 4'b0010, 22'h0));
    stepCycle();
    bus.cop_valid_i = 1'b0;
    applyStimulus(mk(cyc, 3'b001, 1'b1, 8'h48, 2'd2, {4{32'hCAFEF00D}}, 16'hF000, 4'b0000, 22'h0));

    // Zero strobe store is still granted with d_we=1
    stepCycle();
    idle();
    bus.sb_valid_i = 1'b1; bus.sb_addr_i = 10'h004; bus.sb_way_i = 2'd0;
    bus.sb_data_i = 32'h12345678; bus.sb_strb_i = 4'b0000;
    applyStimulus(mk(cyc, 3'b001, 1'b1, 8'h01, 2'd0, {4{32'h12345678}}, 16'h0000, 4'b0000, 22'h0));

    // Starvation: 8 lost cycles, store wins in cycle 9, refill resumes in 10
    rf_n = 0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      rf_word = 32'h5000_0000 + 32'(rf_n);
      bus.rf_valid_i = 1'b1; bus.rf_addr_i = 8'(8'h40 + rf_n); bus.rf_way_i = rf_n[1:0];
      bus.rf_data_i = {4{rf_word}}; bus.rf_tag_i = 22'(22'h100 + rf_n);
      bus.sb_valid_i = (i <= 9); bus.sb_addr_i = 10'h2A5; bus.sb_way_i = 2'd3;
      bus.sb_data_i = 32'hA5A5A5A5; bus.sb_strb_i = 4'b1000;
      if (i == 9) begin
        applyStimulus(mk(cyc, 3'b001, 1'b1, 8'hA9, 2'd3, {4{32'hA5A5A5A5}}, 16'h0080, 4'b0000, 22'h0));
      end else begin
        applyStimulus(mk(cyc, 3'b100, 1'b1, 8'(8'h40 + rf_n), rf_n[1:0], {4{rf_word}}, 16'hFFFF,
                         4'b0001 << rf_n[1:0], 22'(22'h100 + rf_n)));
        rf_n++;
      end
      @(negedge clk);
      if (i == 9) begin
        checkOutput("starve_cnt_limit", dut.u_starve.cnt_q, 4'd8);
        checkOutput("starve_prio_set", dut.sb_prio_q, 1'b1);
      end
      if (i == 10) begin
        checkOutput("starve_cnt_clear", dut.u_starve.cnt_q, 4'd0);
        checkOutput("starve_prio_clear", dut.sb_prio_q, 1'b0);
      end
    end

    // Reset in the middle of a store grant
    stepCycle();
    idle();
    stepCycle();
    bus.rf_valid_i = 1'b1; bus.rf_addr_i = 8'h77; bus.rf_way_i = 2'd1;
    bus.rf_data_i = LINE_C; bus.rf_tag_i = 22'h0ABCD;
    bus.sb_valid_i = 1'b1; bus.sb_addr_i = 10'h3FF; bus.sb_way_i = 2'd0;
    bus.sb_data_i = 32'h11112222; bus.sb_strb_i = 4'b1111;
    applyStimulus(mk(cyc, 3'b100, 1'b1, 8'h77, 2'd1, LINE_C, 16'hFFFF, 4'b0010, 22'h0ABCD));
    stepCycle();
    applyStimulus(mk(cyc, 3'b100, 1'b1, 8'h77, 2'd1, LINE_C, 16'hFFFF, 4'b0010, 22'h0ABCD));
    @(negedge clk);
    checkOutput("pre_rst_cnt", dut.u_starve.cnt_q, 4'd1);
    stepCycle();
    bus.rf_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_sb_ready", bus.sb_ready_o, 1'b0);
    checkOutput("midrst_d_we", bus.d_we_o, 1'b0);
    checkOutput("midrst_d_strb", bus.d_strb_o, 16'h0);
    checkOutput("midrst_cnt_before", dut.u_starve.cnt_q, 4'd2);
    stepCycle();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    checkOutput("postrst_snp_valid", bus.snp_valid_o, 1'b0);
    checkOutput("postrst_snp_d", bus.snp_d_o, 128'h0);
    checkOutput("postrst_snp_dstrb", bus.snp_dstrb_o, 16'h0);
    checkOutput("postrst_snp_taddr", bus.snp_taddr_o, 8'h0);
    checkOutput("postrst_snp_twe", bus.snp_twe_o, 4'h0);
    checkOutput("postrst_snp_tag", bus.snp_tag_o, 22'h0);
    checkOutput("postrst_cnt", dut.u_starve.cnt_q, 4'd0);

    // Drain and confirm every expected write and snoop was seen
    repeat (3) stepCycle();
    checkOutput("wr_queue_left", 128'(wq.size()), 128'h0);
    checkOutput("snp_queue_left", 128'(sq.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
